// File: rtl/cpu86_mem_arbiter_pkg.sv
// cpu86 memory arbiter shared definitions.
//   req_id_t : requester identity carried through the tag FIFO
//   REQ_W    : memory request payload width
//   RES_W    : memory read response width
package cpu86_mem_arb_pkg;

   typedef enum logic {REQ_FETCH = 1'b0, REQ_EXEC = 1'b1} req_id_t;

   localparam int REQ_W = 64;
   localparam int RES_W = 32;

endpackage

// File: rtl/cpu86_mem_arbiter_if.sv
// cpu86 memory arbiter bus bundle.
//   fetch/exec request streams (valid/ready/data, 64 bit)
//   memory request stream (valid/ready/data, 64 bit)
//   memory response stream (valid/data, 32 bit, no backpressure)
//   fetch/exec response streams (valid/data, 32 bit, no backpressure)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding units and memory
interface cpu86_mem_arbiter_if import cpu86_mem_arb_pkg::*; ();

   logic             s_axis_fetch_req_tvalid;
   logic             s_axis_fetch_req_tready;
   logic [REQ_W-1:0] s_axis_fetch_req_tdata;
   logic             s_axis_exec_req_tvalid;
   logic             s_axis_exec_req_tready;
   logic [REQ_W-1:0] s_axis_exec_req_tdata;
   logic             m_axis_mem_req_tvalid;
   logic             m_axis_mem_req_tready;
   logic [REQ_W-1:0] m_axis_mem_req_tdata;
   logic             s_axis_mem_res_tvalid;
   logic [RES_W-1:0] s_axis_mem_res_tdata;
   logic             m_axis_fetch_res_tvalid;
   logic [RES_W-1:0] m_axis_fetch_res_tdata;
   logic             m_axis_exec_res_tvalid;
   logic [RES_W-1:0] m_axis_exec_res_tdata;

   modport slave (
      input  s_axis_fetch_req_tvalid, s_axis_fetch_req_tdata,
      output s_axis_fetch_req_tready,
      input  s_axis_exec_req_tvalid, s_axis_exec_req_tdata,
      output s_axis_exec_req_tready,
      output m_axis_mem_req_tvalid, m_axis_mem_req_tdata,
      input  m_axis_mem_req_tready,
      input  s_axis_mem_res_tvalid, s_axis_mem_res_tdata,
      output m_axis_fetch_res_tvalid, m_axis_fetch_res_tdata,
      output m_axis_exec_res_tvalid, m_axis_exec_res_tdata
   );

   modport master (
      output s_axis_fetch_req_tvalid, s_axis_fetch_req_tdata,
      input  s_axis_fetch_req_tready,
      output s_axis_exec_req_tvalid, s_axis_exec_req_tdata,
      input  s_axis_exec_req_tready,
      input  m_axis_mem_req_tvalid, m_axis_mem_req_tdata,
      output m_axis_mem_req_tready,
      output s_axis_mem_res_tvalid, s_axis_mem_res_tdata,
      input  m_axis_fetch_res_tvalid, m_axis_fetch_res_tdata,
      input  m_axis_exec_res_tvalid, m_axis_exec_res_tdata
   );

endinterface

// File: rtl/cpu86_mem_arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every outstanding read.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : enqueue push_id (ignored when full)
//   pop         : dequeue head (ignored when empty)
//   full, empty : occupancy flags
//   head        : ID of the oldest outstanding read
module cpu86_mem_arb_tag_fifo import cpu86_mem_arb_pkg::*; #(
   parameter int unsigned TAG_DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(TAG_DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic    clk,
   input  logic    resetn,
   input  logic    push,
   input  req_id_t push_id,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output req_id_t head
);

   req_id_t          mem [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem    <= '{default: REQ_FETCH};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CNT_W'(TAG_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/cpu86_mem_arbiter.sv
// cpu86 memory port arbiter: shares one memory request/response port between
// instruction fetch (ID 0) and execution/load-store (ID 1).
//   clk            : system clock
//   resetn         : asynchronous active-low reset
//   bus            : request/response streams (slave modport)
//   err_orphan_res : sticky flag, a response arrived with no outstanding read
// Round-robin grant into a registered output stage; an in-order tag FIFO steers
// each read response back to its requester one cycle after it arrives.
module cpu86_mem_arbiter import cpu86_mem_arb_pkg::*; #(
   parameter int unsigned TAG_DEPTH = 4,
   parameter int unsigned WR_BIT    = 63
) (
   input  logic                clk,
   input  logic                resetn,
   cpu86_mem_arbiter_if.slave  bus,
   output logic                err_orphan_res
);

   req_id_t          last_grant;
   req_id_t          last_grant_nxt;
   req_id_t          grant_id;
   logic             grant_vld;
   logic [REQ_W-1:0] grant_data;
   logic             stage_free;
   logic             elig_fetch;
   logic             elig_exec;
   logic             tag_full;
   logic             tag_empty;
   logic             tag_push;
   logic             tag_pop;
   req_id_t          tag_head;

   assign stage_free = !bus.m_axis_mem_req_tvalid || bus.m_axis_mem_req_tready;

   // Writes never wait on tag space, so a read stalled on a full FIFO cannot
   // block a write from the other side. A same-cycle pop does not free a slot.
   assign elig_fetch = bus.s_axis_fetch_req_tvalid &&
                       (bus.s_axis_fetch_req_tdata[WR_BIT] || !tag_full);
   assign elig_exec  = bus.s_axis_exec_req_tvalid &&
                       (bus.s_axis_exec_req_tdata[WR_BIT] || !tag_full);

   always_comb begin
      grant_vld      = 1'b0;
      grant_id       = REQ_FETCH;
      last_grant_nxt = last_grant;
      if (stage_free) begin
         if (elig_fetch && elig_exec) begin
            grant_vld = 1'b1;
            grant_id  = (last_grant == REQ_FETCH) ? REQ_EXEC : REQ_FETCH;
         end else if (elig_fetch) begin
            grant_vld = 1'b1;
            grant_id  = REQ_FETCH;
         end else if (elig_exec) begin
            grant_vld = 1'b1;
            grant_id  = REQ_EXEC;
         end
      end
      if (grant_vld) begin
         last_grant_nxt = grant_id;
      end
   end

   assign grant_data = (grant_id == REQ_EXEC) ? bus.s_axis_exec_req_tdata
                                              : bus.s_axis_fetch_req_tdata;

   assign bus.s_axis_fetch_req_tready = grant_vld && (grant_id == REQ_FETCH);
   assign bus.s_axis_exec_req_tready  = grant_vld && (grant_id == REQ_EXEC);

   assign tag_push = grant_vld && !grant_data[WR_BIT];
   assign tag_pop  = bus.s_axis_mem_res_tvalid && !tag_empty;

   // Pointer resets to EXEC so the first contested grant goes to fetch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant                <= REQ_EXEC;
         bus.m_axis_mem_req_tvalid <= 1'b0;
         bus.m_axis_mem_req_tdata  <= '0;
      end else begin
         last_grant <= last_grant_nxt;
         if (grant_vld) begin
            bus.m_axis_mem_req_tvalid <= 1'b1;
            bus.m_axis_mem_req_tdata  <= grant_data;
         end else if (bus.m_axis_mem_req_tready) begin
            bus.m_axis_mem_req_tvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.m_axis_fetch_res_tvalid <= 1'b0;
         bus.m_axis_fetch_res_tdata  <= '0;
         bus.m_axis_exec_res_tvalid  <= 1'b0;
         bus.m_axis_exec_res_tdata   <= '0;
         err_orphan_res              <= 1'b0;
      end else begin
         bus.m_axis_fetch_res_tvalid <= tag_pop && (tag_head == REQ_FETCH);
         bus.m_axis_exec_res_tvalid  <= tag_pop && (tag_head == REQ_EXEC);
         if (tag_pop && (tag_head == REQ_FETCH)) begin
            bus.m_axis_fetch_res_tdata <= bus.s_axis_mem_res_tdata;
         end
         if (tag_pop && (tag_head == REQ_EXEC)) begin
            bus.m_axis_exec_res_tdata <= bus.s_axis_mem_res_tdata;
         end
         if (bus.s_axis_mem_res_tvalid && tag_empty) begin
            err_orphan_res <= 1'b1;
         end
      end
   end

   cpu86_mem_arb_tag_fifo #(
      .TAG_DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (tag_push),
      .push_id (grant_id),
      .pop     (tag_pop),
      .full    (tag_full),
      .empty   (tag_empty),
      .head    (tag_head)
   );

endmodule

// File: tb/tb_cpu86_mem_arbiter.sv
// Testbench for cpu86_mem_arbiter: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_cpu86_mem_arbiter;
   import cpu86_mem_arb_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   logic err;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   cpu86_mem_arbiter_if bus ();

   cpu86_mem_arbiter #(
      .TAG_DEPTH (4),
      .WR_BIT    (63)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (bus.slave),
      .err_orphan_res (err)
   );

   // Reference model: outstanding reads as a queue of requester IDs
   int          tagq[$];
   int          grant_last;
   logic        mdl_mvld;
   logic [63:0] mdl_mdata;
   logic        mdl_frv, mdl_erv, mdl_err;
   logic [31:0] mdl_fdat, mdl_edat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      tagq.delete();
      grant_last = 1;
      mdl_mvld   = 1'b0;
      mdl_mdata  = '0;
      mdl_frv    = 1'b0;
      mdl_erv    = 1'b0;
      mdl_err    = 1'b0;
      mdl_fdat   = '0;
      mdl_edat   = '0;
   endtask

   task automatic drive(input logic fv, input logic [63:0] fd, input logic ev,
                        input logic [63:0] ed, input logic mt, input logic rv,
                        input logic [31:0] rd);
      bus.s_axis_fetch_req_tvalid = fv;
      bus.s_axis_fetch_req_tdata  = fd;
      bus.s_axis_exec_req_tvalid  = ev;
      bus.s_axis_exec_req_tdata   = ed;
      bus.m_axis_mem_req_tready   = mt;
      bus.s_axis_mem_res_tvalid   = rv;
      bus.s_axis_mem_res_tdata    = rd;
   endtask

   // Called just after a falling edge with inputs applied; checks and advances one cycle.
   task automatic step();
      logic        free, ef, ee, gf, ge;
      logic [63:0] gd;
      int          id;
      #1;
      free = !mdl_mvld || bus.m_axis_mem_req_tready;
      ef = bus.s_axis_fetch_req_tvalid && (bus.s_axis_fetch_req_tdata[63] || tagq.size() < 4);
      ee = bus.s_axis_exec_req_tvalid && (bus.s_axis_exec_req_tdata[63] || tagq.size() < 4);
      gf = 1'b0;
      ge = 1'b0;
      if (free && ef && ee) begin
         if (grant_last == 0) ge = 1'b1;
         else gf = 1'b1;
      end else if (free && ef) gf = 1'b1;
      else if (free && ee) ge = 1'b1;

      check("fetch_tready", bus.s_axis_fetch_req_tready, gf);
      check("exec_tready", bus.s_axis_exec_req_tready, ge);
      check("mreq_tvalid", bus.m_axis_mem_req_tvalid, mdl_mvld);
      if (mdl_mvld) check("mreq_tdata", bus.m_axis_mem_req_tdata, mdl_mdata);
      check("fetch_res_tvalid", bus.m_axis_fetch_res_tvalid, mdl_frv);
      if (mdl_frv) check("fetch_res_tdata", bus.m_axis_fetch_res_tdata, mdl_fdat);
      check("exec_res_tvalid", bus.m_axis_exec_res_tvalid, mdl_erv);
      if (mdl_erv) check("exec_res_tdata", bus.m_axis_exec_res_tdata, mdl_edat);
      check("err_orphan", err, mdl_err);

      mdl_frv = 1'b0;
      mdl_erv = 1'b0;
      if (bus.s_axis_mem_res_tvalid) begin
         if (tagq.size() > 0) begin
            id = tagq.pop_front();
            if (id == 0) begin
               mdl_frv  = 1'b1;
               mdl_fdat = bus.s_axis_mem_res_tdata;
            end else begin
               mdl_erv  = 1'b1;
               mdl_edat = bus.s_axis_mem_res_tdata;
            end
         end else begin
            mdl_err = 1'b1;
         end
      end
      if (gf || ge) begin
         gd         = gf ? bus.s_axis_fetch_req_tdata : bus.s_axis_exec_req_tdata;
         mdl_mvld   = 1'b1;
         mdl_mdata  = gd;
         grant_last = ge ? 1 : 0;
         if (!gd[63]) tagq.push_back(ge ? 1 : 0);
      end else if (bus.m_axis_mem_req_tready) begin
         mdl_mvld = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mvld"}, bus.m_axis_mem_req_tvalid, 0);
      check({tag, "_mdata"}, bus.m_axis_mem_req_tdata, 0);
      check({tag, "_frv"}, bus.m_axis_fetch_res_tvalid, 0);
      check({tag, "_fdat"}, bus.m_axis_fetch_res_tdata, 0);
      check({tag, "_erv"}, bus.m_axis_exec_res_tvalid, 0);
      check({tag, "_edat"}, bus.m_axis_exec_res_tdata, 0);
      check({tag, "_ftrdy"}, bus.s_axis_fetch_req_tready, 0);
      check({tag, "_etrdy"}, bus.s_axis_exec_req_tready, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      logic [63:0] fd, ed;
      logic        rv;

      resetn = 1'b0;
      drive(0, '0, 0, '0, 1, 0, '0);
      model_reset();
      repeat (3) @(negedge clk);
      #1 check_all_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      // 1: single fetch read
      drive(1, 64'h0000_0000_0001_0000, 0, '0, 1, 0, '0);
      step();
      check("t1_mvld", bus.m_axis_mem_req_tvalid, 1);
      check("t1_mdata", bus.m_axis_mem_req_tdata, 64'h0000_0000_0001_0000);
      drive(0, '0, 0, '0, 1, 0, '0);
      step();
      drive(0, '0, 0, '0, 1, 1, 32'hCAFE_0001);
      step();
      check("t1_frv", bus.m_axis_fetch_res_tvalid, 1);
      check("t1_fdat", bus.m_axis_fetch_res_tdata, 32'hCAFE_0001);
      check("t1_erv", bus.m_axis_exec_res_tvalid, 0);
      drive(0, '0, 0, '0, 1, 0, '0);
      step();
      check("t1_pulse", bus.m_axis_fetch_res_tvalid, 0);

      // exec write so the pointer favours fetch for the next contest
      drive(0, '0, 1, 64'h8000_0000_0000_0100, 1, 0, '0);
      step();

      // 2: both read continuously, grants alternate F,E,F,E
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'h1000, 1, 64'h2000, 1, 0, '0);
         step();
         check("t2_grant", bus.m_axis_mem_req_tdata, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, 0, '0, 1, 1, 32'hD000_0000 + 32'(i));
         step();
         check("t2_frv", bus.m_axis_fetch_res_tvalid, (i % 2 == 0) ? 1 : 0);
         check("t2_erv", bus.m_axis_exec_res_tvalid, (i % 2 == 0) ? 0 : 1);
         check("t2_dat", (i % 2 == 0) ? bus.m_axis_fetch_res_tdata : bus.m_axis_exec_res_tdata,
               32'hD000_0000 + 32'(i));
      end

      // 3: exec fills the tag FIFO, fetch write still goes through
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, 1, 64'h3000 + 64'(i), 1, 0, '0);
         step();
      end
      drive(1, 64'h8000_0000_0000_4000, 1, 64'h3005, 1, 0, '0);
      #1;
      check("t3_exec_blocked", bus.s_axis_exec_req_tready, 0);
      check("t3_fetch_wr", bus.s_axis_fetch_req_tready, 1);
      step();
      drive(0, '0, 1, 64'h3005, 1, 1, 32'hE000_0000);
      #1 check("t3_pop_no_credit", bus.s_axis_exec_req_tready, 0);
      step();
      drive(0, '0, 1, 64'h3005, 1, 0, '0);
      #1 check("t3_exec_ok", bus.s_axis_exec_req_tready, 1);
      step();
      check("t3_mdata", bus.m_axis_mem_req_tdata, 64'h3005);
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, 0, '0, 1, 1, 32'hE000_0010 + 32'(i));
         step();
         check("t3_drain", bus.m_axis_exec_res_tvalid, 1);
      end

      // 4: stalled output stage
      drive(1, 64'h8000_0000_0000_00F1, 1, 64'h8000_0000_0000_00E1, 0, 0, '0);
      step();
      check("t4_first", bus.m_axis_mem_req_tdata, 64'h8000_0000_0000_00F1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_hold_vld", bus.m_axis_mem_req_tvalid, 1);
         check("t4_hold_dat", bus.m_axis_mem_req_tdata, 64'h8000_0000_0000_00F1);
         check("t4_no_ftrdy", bus.s_axis_fetch_req_tready, 0);
      end
      bus.m_axis_mem_req_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_flow", bus.m_axis_mem_req_tdata,
               (i % 2 == 0) ? 64'h8000_0000_0000_00E1 : 64'h8000_0000_0000_00F1);
      end

      // random traffic
      for (int c = 0; c < 400; c++) begin
         fd = {$urandom(), $urandom()};
         fd[63] = ($urandom_range(0, 2) == 0);
         ed = {$urandom(), $urandom()};
         ed[63] = ($urandom_range(0, 2) == 0);
         rv = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
         drive($urandom_range(0, 1) == 1, fd, $urandom_range(0, 1) == 1, ed,
               $urandom_range(0, 3) != 0, rv, $urandom());
         step();
      end
      for (int k = 0; k < 20 && tagq.size() > 0; k++) begin
         drive(0, '0, 0, '0, 1, 1, $urandom());
         step();
      end
      drive(0, '0, 0, '0, 1, 0, '0);
      step();
      check("drain_empty", tagq.size(), 0);

      // 5: orphan response
      drive(0, '0, 0, '0, 1, 1, 32'hBAD0_0000);
      step();
      check("t5_frv", bus.m_axis_fetch_res_tvalid, 0);
      check("t5_erv", bus.m_axis_exec_res_tvalid, 0);
      check("t5_err", err, 1);
      drive(0, '0, 0, '0, 1, 0, '0);
      step();
      step();
      check("t5_sticky", err, 1);

      // 6: reset with 3 outstanding reads
      drive(1, 64'h5000, 1, 64'h6000, 1, 0, '0);
      step();
      step();
      step();
      drive(0, '0, 0, '0, 1, 0, '0);
      #1 resetn = 1'b0;
      #1 check_all_zero("t6_reset");
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      drive(0, '0, 0, '0, 1, 1, 32'h1234_5678);
      step();
      check("t6_orphan", err, 1);
      check("t6_frv", bus.m_axis_fetch_res_tvalid, 0);
      check("t6_erv", bus.m_axis_exec_res_tvalid, 0);
      drive(0, '0, 0, '0, 1, 0, '0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
